sync_fifo_flex: RTL and testbench
=================================

# sync_fifo_flex

Parametrised single-clock FIFO for wide byte-vector traffic between MiniGPU pipeline stages. It stores 8*WIDTH-bit words and is the general-purpose replacement for fixed stage buffers. It adds a selectable read mode (first-word-fall-through or registered), occupancy count, almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags.

## Interface
- WIDTH, 256: word size in bytes; data ports are 8*WIDTH bits.
- DEPTH, 8: capacity in words; power of two, ≥2.
- FWFT, 1: 1 = show-ahead read, 0 = registered read.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL.
- Constant AW = log2(DEPTH); count is AW+1 bits.

- CLK  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- data_in  in  8*WIDTH  write data.
- rd_en  in  1  read/pop request.
- data_out  out  8*WIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  AW+1  words currently stored.
- overflow  out  1  sticky: write attempted while full and not popped.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Storage: DEPTH-entry array, wptr/rptr of AW bits wrapping modulo DEPTH; count register tracks occupancy (no pointer-extension compare).
- Write accepted (wr_ok) when wr_en && (!full || rd_ok). Data goes to mem[wptr] and wptr advances.
- Read accepted (rd_ok) when rd_en && !empty. rptr advances.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Full with rd_en && wr_en: both accepted, count stays DEPTH.
- Empty with rd_en && wr_en: write accepted, read rejected, underflow sets, count becomes 1.
- wr_en while full without rd_ok: write dropped, overflow sets.
- FWFT=1: data_out = mem[rptr] whenever !empty and 0 when empty. rd_en acknowledges the shown word.
- FWFT=0: data_out is a register loaded with mem[rptr] on rd_ok and holds otherwise.
- All flags are decoded combinationally from registered count.
- flush beats wr_en/rd_en in the same cycle. It zeroes pointers, count, overflow, underflow and the FWFT=0 data_out register. Array contents are not cleared.
- rst (async) has the same effect as flush and takes effect immediately, including mid-transfer.

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0 (AF_LEVEL ≥1), overflow 0, underflow 0, data_out 0.
- Write latency: wr_ok at edge N makes count/empty reflect it after edge N. With FWFT=1, data_out shows the word in cycle N+1.
- Read latency, FWFT=1: 0 cycles; the next word appears after the rd_ok edge.
- Read latency, FWFT=0: 1 cycle; data_out is valid after the rd_ok edge.
- Throughput is one write and one read per cycle sustained, including at full and at empty boundaries as defined above.
- Pointer wrap from DEPTH-1 to 0 needs no bubble.
- Sticky flags set on the edge of the offending request and hold until flush/rst.

## Structure
- Shared package/header fifo_pkg holds clog2-based AW derivation and the parameter legality checks: DEPTH power of two ≥2, AE_LEVEL < AF_LEVEL ≤ DEPTH. The checks elaborate-time error.
- One sub-module, sync_fifo_ram: DEPTH×8*WIDTH array with one synchronous write port and one asynchronous read port, no reset.
- Top holds pointers, count, flag decode, mode mux and error flags. Estimated 150–250 RTL lines.

## Test plan
- Reset, then write 0xA1..0xA8 (DEPTH=8, FWFT=1): after the 8th write, full=1 and count=8. Read 8 times: words return A1..A8 in order, empty=1.
- FWFT=0: write 0x55, pulse rd_en at edge N: data_out=0x55 after N, holds while rd_en=0.
- At full, assert wr_en+rd_en with 0x77 for 3 cycles: count stays 8, no overflow, 0x77 ×3 emerges after the original 8.
- wr_en at full without rd_en → overflow=1 and data dropped. rd_en at empty → underflow=1. Both stay set until flush, then clear with count=0.
- AF_LEVEL=6, AE_LEVEL=2: fill 0→8 and drain. almost_empty is high for count ≤2 and almost_full is high for count ≥6, each changing on the exact count edge.
- Assert rst asynchronously mid-burst (count=5): all outputs hit reset values without a clock edge. Resume writes: the first word read back is the first word written after reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for sync_fifo_flex: pointer-width derivation and the
// parameter legality checks evaluated at elaboration.
package fifo_pkg;

   function automatic int fifo_aw(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic bit fifo_depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic bit fifo_levels_ok(input int depth, input int af_level, input int ae_level);
      return (ae_level < af_level) && (af_level <= depth);
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_flex: one synchronous write port and one
// asynchronous read port, no reset.
module sync_fifo_ram #(
   parameter int DW    = 2048,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with selectable show-ahead/registered read,
// occupancy count, almost thresholds, synchronous flush and sticky error flags.
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int   WIDTH    = 256,
   parameter int   DEPTH    = 8,
   parameter int   FWFT     = 1,
   parameter int   AF_LEVEL = DEPTH - 1,
   parameter int   AE_LEVEL = 1,
   localparam int  AW       = fifo_aw(DEPTH)
) (
   input  logic               CLK,
   input  logic               rst,
   input  logic               flush,
   input  logic               wr_en,
   input  logic [8*WIDTH-1:0] data_in,
   input  logic               rd_en,
   output logic [8*WIDTH-1:0] data_out,
   output logic               empty,
   output logic               full,
   output logic               almost_full,
   output logic               almost_empty,
   output logic [AW:0]        count,
   output logic               overflow,
   output logic               underflow
);

   localparam int          DW        = 8 * WIDTH;
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0] AF_CNT    = (AW + 1)'(AF_LEVEL);
   localparam logic [AW:0] AE_CNT    = (AW + 1)'(AE_LEVEL);

   generate
      if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
         $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
      end
      if (!fifo_levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
         $error("sync_fifo_flex: need AE_LEVEL < AF_LEVEL <= DEPTH");
      end
   endgenerate

   logic [AW-1:0] wptr_reg;
   logic [AW-1:0] rptr_reg;
   logic [AW:0]   count_reg;
   logic          overflow_reg;
   logic          underflow_reg;
   logic          rd_ok;
   logic          wr_ok;
   logic [DW-1:0] rd_data;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts a write.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   sync_fifo_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .CLK   (CLK),
      .we    (wr_ok && !flush),
      .waddr (wptr_reg),
      .wdata (data_in),
      .raddr (rptr_reg),
      .rdata (rd_data)
   );

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (flush) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_ok) begin
            wptr_reg <= wptr_reg + 1'b1;
         end
         if (rd_ok) begin
            rptr_reg <= rptr_reg + 1'b1;
         end
         if (wr_ok && !rd_ok) begin
            count_reg <= count_reg + 1'b1;
         end else if (rd_ok && !wr_ok) begin
            count_reg <= count_reg - 1'b1;
         end
         if (wr_en && !wr_ok) begin
            overflow_reg <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign count        = count_reg;
   assign empty        = (count_reg == '0);
   assign full         = (count_reg == DEPTH_CNT);
   assign almost_full  = (count_reg >= AF_CNT);
   assign almost_empty = (count_reg <= AE_CNT);
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : rd_data;
      end else begin : g_reg
         logic [DW-1:0] dout_reg;

         always_ff @(posedge CLK or posedge rst) begin
            if (rst) begin
               dout_reg <= '0;
            end else if (flush) begin
               dout_reg <= '0;
            end else if (rd_ok) begin
               dout_reg <= rd_data;
            end
         end

         assign data_out = dout_reg;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a show-ahead and a registered-read instance share
// stimulus; a queue-based reference model and read scoreboard check both.
module tb_sync_fifo_flex;

   localparam int WIDTH = 4;
   localparam int DW    = 8 * WIDTH;
   localparam int DEPTH = 8;

   logic          CLK = 1'b0;
   logic          rst;
   logic          flush;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          rd_en;

   logic [DW-1:0] a_dout;
   logic          a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
   logic [3:0]    a_count;
   logic [DW-1:0] b_dout;
   logic          b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
   logic [3:0]    b_count;

   always #5 CLK = ~CLK;

   sync_fifo_flex #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)
   ) u_dut (
      .CLK(CLK), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(a_dout), .empty(a_empty), .full(a_full),
      .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
      .overflow(a_ovf), .underflow(a_unf)
   );

   sync_fifo_flex #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)
   ) u_reg (
      .CLK(CLK), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(b_dout), .empty(b_empty), .full(b_full),
      .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
      .overflow(b_ovf), .underflow(b_unf)
   );

   // Reference model: contents as a plain queue plus sticky flags and the
   // registered-read output word.
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_q[$];
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;
   logic [DW-1:0] m_dreg = '0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      model_q.delete();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dreg = '0;
   endtask

   task automatic model_apply(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
      bit can_rd;
      bit can_wr;
      can_rd = r && (model_q.size() > 0);
      can_wr = w && ((model_q.size() < DEPTH) || can_rd);
      if (f) begin
         model_q.delete();
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_dreg = '0;
      end else begin
         if (w && !can_wr) m_ovf = 1'b1;
         if (r && model_q.size() == 0) m_unf = 1'b1;
         if (can_rd) m_dreg = model_q.pop_front();
         if (can_wr) model_q.push_back(d);
      end
   endtask

   // One clock of stimulus; an accepted read queues its expected word.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      flush   = f;
      if (!f && r && model_q.size() > 0) exp_q.push_back(model_q[0]);
      @(posedge CLK);
      model_apply(w, d, r, f);
      #1;
      $display("[TB] t=%0t wr=%0b din=%0h rd=%0b flush=%0b -> count=%0d", $time, w, d, r, f, model_q.size());
   endtask

   task automatic check_reset_state();
      check("rst_count", 64'(a_count), 64'd0);
      check("rst_empty", 64'(a_empty), 64'd1);
      check("rst_full", 64'(a_full), 64'd0);
      check("rst_ae", 64'(a_ae), 64'd1);
      check("rst_af", 64'(a_af), 64'd0);
      check("rst_ovf", 64'(a_ovf), 64'd0);
      check("rst_unf", 64'(a_unf), 64'd0);
      check("rst_dout_fwft", 64'(a_dout), 64'd0);
      check("rst_dout_reg", 64'(b_dout), 64'd0);
      check("rst_count_reg", 64'(b_count), 64'd0);
   endtask

   // Monitor: on the falling edge compare both instances with the model and
   // retire scoreboard entries whenever the show-ahead FIFO presents a pop.
   always @(negedge CLK) begin
      int sz;
      sz = model_q.size();
      check("count", 64'(a_count), 64'(sz));
      check("empty", 64'(a_empty), 64'(sz == 0));
      check("full", 64'(a_full), 64'(sz == DEPTH));
      check("almost_full", 64'(a_af), 64'(sz >= 6));
      check("almost_empty", 64'(a_ae), 64'(sz <= 2));
      check("overflow", 64'(a_ovf), 64'(m_ovf));
      check("underflow", 64'(a_unf), 64'(m_unf));
      check("reg_count", 64'(b_count), 64'(sz));
      check("reg_almost_full", 64'(b_af), 64'(sz >= DEPTH - 1));
      check("reg_almost_empty", 64'(b_ae), 64'(sz <= 1));
      check("reg_overflow", 64'(b_ovf), 64'(m_ovf));
      check("reg_underflow", 64'(b_unf), 64'(m_unf));
      check("reg_data_out", 64'(b_dout), 64'(m_dreg));
      if (sz == 0) check("fwft_empty_data", 64'(a_dout), 64'd0);
      if (!rst && rd_en && !flush && !a_empty) begin
         if (exp_q.size() == 0) begin
            check("unexpected_read", 64'(a_dout), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check("read_data", 64'(a_dout), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      logic [DW-1:0] w;
      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      @(posedge CLK);
      #1;
      check_reset_state();
      rst = 1'b0;

      // Fill with A1..A8, then drain in order.
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'hA1 + i), 1'b0, 1'b0);
      check("fill_full", 64'(a_full), 64'd1);
      check("fill_count", 64'(a_count), 64'd8);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("drain_empty", 64'(a_empty), 64'd1);

      // Registered read: 0x55 appears after the pop edge and holds.
      step(1'b1, DW'(32'h55), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("reg_read_55", 64'(b_dout), 64'h55);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
      check("reg_hold_55", 64'(b_dout), 64'h55);

      // Simultaneous push/pop at full, then a dropped write.
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h77), 1'b1, 1'b0);
      check("full_rw_count", 64'(a_count), 64'd8);
      check("full_rw_no_ovf", 64'(a_ovf), 64'd0);
      step(1'b1, DW'(32'hDEAD), 1'b0, 1'b0);
      check("ovf_set", 64'(a_ovf), 64'd1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("unf_set", 64'(a_unf), 64'd1);
      check("ovf_sticky", 64'(a_ovf), 64'd1);
      step(1'b1, DW'(32'hBEEF), 1'b1, 1'b0);
      check("empty_rw_count", 64'(a_count), 64'd1);
      step(1'b1, DW'(32'h1234), 1'b1, 1'b1);
      check("flush_count", 64'(a_count), 64'd0);
      check("flush_ovf", 64'(a_ovf), 64'd0);
      check("flush_unf", 64'(a_unf), 64'd0);

      // Randomised traffic: write-heavy, then read-heavy, rare flushes.
      for (int i = 0; i < 400; i++) begin
         bit wb, rb, fb;
         if (i < 200) begin
            wb = ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 3) == 0);
         end else begin
            wb = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 3) != 0);
         end
         fb = ($urandom_range(0, 59) == 0);
         step(wb, DW'($urandom), rb, fb);
      end

      // Asynchronous reset mid-burst at count 5.
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      check("pre_rst_count", 64'(a_count), 64'd5);
      wr_en = 1'b1;
      data_in = DW'(32'hCAFE);
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      check_reset_state();
      wr_en = 1'b0;
      @(posedge CLK);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w = DW'(32'hF00 + i);
         step(1'b1, w, 1'b0, 1'b0);
      end
      check("post_rst_first", 64'(a_dout), 64'hF00);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
